// File: rtl/alu_6502.sv
// alu_6502 -- 8-bit ALU for the 6502 datapath.
//
// It computes the result and the N/Z/V/C flags combinationally from the
// operands, the opcode, the carry-in and the decimal-mode select. It also
// keeps a registered copy of the result and flags for the next pipeline stage.
//
// Ports
//   clk       system clock; the registered outputs update on its rising edge
//   reset     synchronous active-high; clears y_q and flags_q only
//   a         operand A (accumulator side; the shifts operate on A)
//   b         operand B (memory side)
//   op        operation select (see the case statement below)
//   c_in      carry in
//   bcd       decimal mode; affects ADD and SUB only
//   y         combinational result
//   zero      combinational Z flag
//   negative  combinational N flag
//   overflow  combinational V flag
//   c_out     combinational C flag
//   y_q       registered result
//   flags_q   registered {negative, overflow, zero, c_out}
module alu_6502 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   input  logic             c_in,
   input  logic             bcd,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             negative,
   output logic             overflow,
   output logic             c_out,
   output logic [WIDTH-1:0] y_q,
   output logic [3:0]       flags_q
);

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_OR  = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_EOR = 4'h4;
   localparam logic [3:0] OP_INC = 4'h5;
   localparam logic [3:0] OP_DEC = 4'h6;
   localparam logic [3:0] OP_ASL = 4'h7;
   localparam logic [3:0] OP_ROL = 4'h8;
   localparam logic [3:0] OP_ROR = 4'h9;
   localparam logic [3:0] OP_LSR = 4'hA;
   localparam logic [3:0] OP_PSA = 4'hB;
   localparam logic [3:0] OP_PSB = 4'hC;

   // Binary add and subtract. Bit 8 of bin_sum is the carry. Bit 8 of
   // bin_diff is the borrow, so the 6502 carry for SBC is its inverse.
   logic [8:0] bin_sum;
   logic [8:0] bin_diff;
   logic       add_ovf;
   logic       sub_ovf;

   assign bin_sum  = {1'b0, a} + {1'b0, b} + 9'(c_in);
   assign bin_diff = {1'b0, a} - {1'b0, b} - 9'(!c_in);
   assign add_ovf  = (a[7] == b[7]) && (bin_sum[7]  != a[7]);
   assign sub_ovf  = (a[7] != b[7]) && (bin_diff[7] != a[7]);

   // Decimal add: each nibble sum above 9 gets +6, and the decimal carry
   // ripples into the high nibble. The sums are 5 bits wide, so invalid
   // digits still give a defined (if meaningless) result.
   logic [4:0] dadd_lo_sum;
   logic [4:0] dadd_hi_sum;
   logic       dadd_lo_c;
   logic       dadd_hi_c;
   logic [3:0] dadd_lo;
   logic [3:0] dadd_hi;

   assign dadd_lo_sum = {1'b0, a[3:0]} + {1'b0, b[3:0]} + 5'(c_in);
   assign dadd_lo_c   = dadd_lo_sum > 5'd9;
   assign dadd_lo     = dadd_lo_sum[3:0] + (dadd_lo_c ? 4'd6 : 4'd0);
   assign dadd_hi_sum = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'(dadd_lo_c);
   assign dadd_hi_c   = dadd_hi_sum > 5'd9;
   assign dadd_hi     = dadd_hi_sum[3:0] + (dadd_hi_c ? 4'd6 : 4'd0);

   // Decimal subtract: when a nibble borrows (bit 4 of its 5-bit difference
   // is set), 6 is taken off that digit.
   logic [4:0] dsub_lo_diff;
   logic [4:0] dsub_hi_diff;
   logic       dsub_lo_b;
   logic       dsub_hi_b;
   logic [3:0] dsub_lo;
   logic [3:0] dsub_hi;

   assign dsub_lo_diff = {1'b0, a[3:0]} - {1'b0, b[3:0]} - 5'(!c_in);
   assign dsub_lo_b    = dsub_lo_diff[4];
   assign dsub_lo      = dsub_lo_diff[3:0] - (dsub_lo_b ? 4'd6 : 4'd0);
   assign dsub_hi_diff = {1'b0, a[7:4]} - {1'b0, b[7:4]} - 5'(dsub_lo_b);
   assign dsub_hi_b    = dsub_hi_diff[4];
   assign dsub_hi      = dsub_hi_diff[3:0] - (dsub_hi_b ? 4'd6 : 4'd0);

   always_comb begin
      y        = a;
      c_out    = c_in;
      overflow = 1'b0;
      case (op)
         OP_ADD: begin
            overflow = add_ovf;
            if (bcd) begin
               y     = {dadd_hi, dadd_lo};
               c_out = dadd_hi_c;
            end else begin
               y     = bin_sum[7:0];
               c_out = bin_sum[8];
            end
         end
         OP_SUB: begin
            overflow = sub_ovf;
            if (bcd) begin
               y     = {dsub_hi, dsub_lo};
               c_out = !dsub_hi_b;
            end else begin
               y     = bin_diff[7:0];
               c_out = !bin_diff[8];
            end
         end
         OP_OR:  y = a | b;
         OP_AND: y = a & b;
         OP_EOR: y = a ^ b;
         OP_INC: y = a + 8'd1;
         OP_DEC: y = a - 8'd1;
         OP_ASL: begin
            y     = {a[6:0], 1'b0};
            c_out = a[7];
         end
         OP_ROL: begin
            y     = {a[6:0], c_in};
            c_out = a[7];
         end
         OP_ROR: begin
            y     = {c_in, a[7:1]};
            c_out = a[0];
         end
         OP_LSR: begin
            y     = {1'b0, a[7:1]};
            c_out = a[0];
         end
         OP_PSA: y = a;
         OP_PSB: y = b;
         default: y = a;   // D-F behave as PASSA
      endcase
   end

   assign zero     = (y == 8'h00);
   assign negative = y[7];

   always_ff @(posedge clk) begin
      if (reset) begin
         y_q     <= '0;
         flags_q <= 4'b0000;
      end else begin
         y_q     <= y;
         flags_q <= {negative, overflow, zero, c_out};
      end
   end

endmodule

// File: tb/tb_alu_6502.sv
module tb_alu_6502;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic [3:0] op = 4'h0;
   logic       c_in = 1'b0;
   logic       bcd = 1'b0;
   logic [7:0] y;
   logic       zero, negative, overflow, c_out;
   logic [7:0] y_q;
   logic [3:0] flags_q;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_6502 dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .c_in(c_in),
      .bcd(bcd), .y(y), .zero(zero), .negative(negative),
      .overflow(overflow), .c_out(c_out), .y_q(y_q), .flags_q(flags_q)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int bcd2int(input logic [7:0] v);
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [7:0] int2bcd(input int v);
      logic [3:0] tens, ones;
      tens = 4'(v / 10);
      ones = 4'(v % 10);
      return {tens, ones};
   endfunction

   function automatic int sgn(input logic [7:0] v);
      return (int'(v) >= 128) ? int'(v) - 256 : int'(v);
   endfunction

   // Reference model built from integer arithmetic; returns {y, n, v, z, c}.
   function automatic logic [11:0] ref_alu(input logic [7:0] av, input logic [7:0] bv,
                                           input logic [3:0] opv, input logic ci,
                                           input logic dec);
      int ua, ub, ic, r, sr, d;
      logic [7:0] yv;
      logic cv, vv;
      ua = int'(av); ub = int'(bv); ic = ci ? 1 : 0;
      yv = av; cv = ci; vv = 1'b0;
      case (opv)
         4'h0: begin
            sr = sgn(av) + sgn(bv) + ic;
            vv = (sr > 127) || (sr < -128);
            if (dec) begin
               d  = bcd2int(av) + bcd2int(bv) + ic;
               cv = d >= 100;
               yv = int2bcd(d % 100);
            end else begin
               r  = ua + ub + ic;
               cv = r > 255;
               yv = 8'(r);
            end
         end
         4'h1: begin
            sr = sgn(av) - sgn(bv) - (1 - ic);
            vv = (sr > 127) || (sr < -128);
            if (dec) begin
               d  = bcd2int(av) - bcd2int(bv) - (1 - ic);
               cv = d >= 0;
               yv = int2bcd((d + 100) % 100);
            end else begin
               r  = ua - ub - (1 - ic);
               cv = r >= 0;
               yv = 8'(r);
            end
         end
         4'h2: yv = av | bv;
         4'h3: yv = av & bv;
         4'h4: yv = av ^ bv;
         4'h5: yv = 8'(ua + 1);
         4'h6: yv = 8'(ua + 255);
         4'h7: begin yv = 8'(ua * 2);      cv = ua >= 128; end
         4'h8: begin yv = 8'(ua * 2 + ic); cv = ua >= 128; end
         4'h9: begin yv = 8'(ua / 2 + ic * 128); cv = (ua % 2) == 1; end
         4'hA: begin yv = 8'(ua / 2);      cv = (ua % 2) == 1; end
         4'hC: yv = bv;
         default: yv = av;
      endcase
      return {yv, yv >= 8'h80, vv, yv == 8'h00, cv};
   endfunction

   // Directed vector: the expected y and flags {n,v,z,c} are written out by hand.
   task automatic dir(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic [3:0] opv, input logic ci, input logic dec,
                      input logic [7:0] ey, input logic [3:0] ef);
      a = av; b = bv; op = opv; c_in = ci; bcd = dec;
      #1;
      chk({tag, "_y"}, 32'(y), 32'(ey));
      chk({tag, "_nvzc"}, 32'({negative, overflow, zero, c_out}), 32'(ef));
   endtask

   logic [11:0] exp_v;
   logic [7:0]  exp_yq;
   logic [3:0]  exp_fq;

   initial begin
      // Combinational directed vectors; {n,v,z,c}.
      dir("add_33_22",  8'h33, 8'h22, 4'h0, 1'b0, 1'b0, 8'h55, 4'b0000);
      dir("add_ff_00c", 8'hFF, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00, 4'b0011);
      dir("add_7f_01",  8'h7F, 8'h01, 4'h0, 1'b0, 1'b0, 8'h80, 4'b1100);
      dir("or",         8'hF0, 8'h1F, 4'h2, 1'b1, 1'b0, 8'hFF, 4'b1001);
      dir("and",        8'hF0, 8'h1F, 4'h3, 1'b1, 1'b0, 8'h10, 4'b0001);
      dir("eor",        8'hF0, 8'h1F, 4'h4, 1'b1, 1'b0, 8'hEF, 4'b1001);
      dir("asl",        8'hFF, 8'h00, 4'h7, 1'b0, 1'b0, 8'hFE, 4'b1001);
      dir("rol",        8'hFF, 8'h00, 4'h8, 1'b0, 1'b0, 8'hFE, 4'b1001);
      dir("ror",        8'hFF, 8'h00, 4'h9, 1'b0, 1'b0, 8'h7F, 4'b0001);
      dir("lsr",        8'hFF, 8'h00, 4'hA, 1'b0, 1'b0, 8'h7F, 4'b0001);
      dir("ror_01c",    8'h01, 8'h00, 4'h9, 1'b1, 1'b0, 8'h80, 4'b1001);
      dir("sub_05_03",  8'h05, 8'h03, 4'h1, 1'b1, 1'b0, 8'h02, 4'b0001);
      dir("sub_03_05",  8'h03, 8'h05, 4'h1, 1'b1, 1'b0, 8'hFE, 4'b1000);
      dir("sub_80_01",  8'h80, 8'h01, 4'h1, 1'b1, 1'b0, 8'h7F, 4'b0101);
      dir("bcd_19_28",  8'h19, 8'h28, 4'h0, 1'b0, 1'b1, 8'h47, 4'b0000);
      dir("bcd_99_01",  8'h99, 8'h01, 4'h0, 1'b0, 1'b1, 8'h00, 4'b0011);
      dir("bcd_42_15",  8'h42, 8'h15, 4'h1, 1'b1, 1'b1, 8'h27, 4'b0001);
      dir("inc_ff",     8'hFF, 8'h00, 4'h5, 1'b0, 1'b0, 8'h00, 4'b0010);
      dir("dec_00",     8'h00, 8'h00, 4'h6, 1'b1, 1'b0, 8'hFF, 4'b1001);
      dir("passb",      8'h12, 8'h00, 4'hC, 1'b0, 1'b1, 8'h00, 4'b0010);
      dir("op_d",       8'h9A, 8'h55, 4'hD, 1'b1, 1'b1, 8'h9A, 4'b1001);

      // Registered outputs.
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_yq", 32'(y_q), 32'h00);
      chk("rst_fq", 32'(flags_q), 32'h0);
      @(negedge clk); reset = 1'b0;
      a = 8'h33; b = 8'h22; op = 4'h0; c_in = 1'b0; bcd = 1'b0;
      @(posedge clk); #1;
      chk("reg_yq_55", 32'(y_q), 32'h55);
      chk("reg_fq_55", 32'(flags_q), 32'h0);
      @(negedge clk); a = 8'h7F; b = 8'h01;
      @(posedge clk); #1;
      chk("reg_yq_80", 32'(y_q), 32'h80);
      chk("reg_fq_80", 32'(flags_q), 32'hC);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      chk("midrst_yq", 32'(y_q), 32'h00);
      chk("midrst_fq", 32'(flags_q), 32'h0);
      chk("midrst_y",  32'(y), 32'h80);
      @(negedge clk); reset = 1'b0;

      // Random stimulus against the reference model; BCD operands are valid digits.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         op    = 4'($urandom_range(0, 15));
         bcd   = 1'($urandom);
         c_in  = 1'($urandom);
         reset = ($urandom_range(0, 9) == 0);
         if (bcd && (op <= 4'h1)) begin
            a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         end else begin
            a = 8'($urandom);
            b = 8'($urandom);
         end
         exp_v = ref_alu(a, b, op, c_in, bcd);
         #1;
         chk("rnd_y", 32'(y), 32'(exp_v[11:4]));
         chk("rnd_nvzc", 32'({negative, overflow, zero, c_out}), 32'(exp_v[3:0]));
         exp_yq = reset ? 8'h00 : exp_v[11:4];
         exp_fq = reset ? 4'h0  : exp_v[3:0];
         @(posedge clk); #1;
         chk("rnd_yq", 32'(y_q), 32'(exp_yq));
         chk("rnd_fq", 32'(flags_q), 32'(exp_fq));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
